uart_rx_word: RTL and testbench

Serial-to-word receiver for the MIRCore UART link: it takes the incoming 8N1 bit stream, assembles four bytes into one 32-bit word, and presents that word to the core with a valid/ack handshake. It is the receive-side counterpart of the data memory's transmit word register (`UART_out`). It sits between the board RX pin and the core's UART load path (the `UARTC` read decode), all in the single `clk` domain.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_byte.sv | 114 +++++++++++
 rtl/uart_rx_word.sv | 95 +++++++++
 tb/tb_uart_rx_word.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the MIRCore UART link: FSM states, frame size and
// the UARTC load/store decode codes used by both transmitter and receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS = 8;

    localparam logic [2:0] UARTC_TX_LO = 3'b011;
    localparam logic [2:0] UARTC_TX_HI = 3'b100;
    localparam logic [2:0] UARTC_RX_RD = 3'b010;

    function automatic logic uart_is_busy(input uart_state_t state);
        return (state != UART_IDLE);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, mid-bit sampling FSM and baud counter.
// byte_done/byte_err are single-cycle strobes, high in the stop-bit sample cycle.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_byte_data,
    output logic                 o_byte_done,
    output logic                 o_byte_err,
    output logic                 o_busy
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] HALF_M1  = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_M1  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

    logic [1:0]           r_sync;
    uart_state_t          r_state;
    logic [BAUD_W-1:0]    r_baud;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;

    uart_state_t          w_state_nxt;
    logic [BAUD_W-1:0]    w_baud_nxt;
    logic [BIT_W-1:0]     w_bit_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 w_rx_s;
    logic                 w_done;
    logic                 w_err;

    assign w_rx_s = r_sync[1];

    // Synchronizer and FSM state registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync    <= 2'b11;
            r_state   <= UART_IDLE;
            r_baud    <= {BAUD_W{1'b0}};
            r_bit_cnt <= {BIT_W{1'b0}};
            r_shift   <= {DATA_BITS{1'b0}};
        end else begin
            r_sync    <= {r_sync[0], i_rx};
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_cnt <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    // Next-state and sample strobes; the baud counter restarts on every sample
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud + 1'b1;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_done      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            UART_IDLE: begin
                w_baud_nxt = {BAUD_W{1'b0}};
                w_bit_nxt  = {BIT_W{1'b0}};
                if (!w_rx_s) begin
                    w_state_nxt = UART_START;
                end else begin
                    w_state_nxt = UART_IDLE;
                end
            end
            UART_START: begin
                if (r_baud == HALF_M1) begin
                    w_baud_nxt  = {BAUD_W{1'b0}};
                    w_state_nxt = w_rx_s ? UART_IDLE : UART_DATA;
                end else begin
                    w_state_nxt = UART_START;
                end
            end
            UART_DATA: begin
                if (r_baud == FULL_M1) begin
                    w_baud_nxt  = {BAUD_W{1'b0}};
                    w_shift_nxt = {w_rx_s, r_shift[DATA_BITS-1:1]};
                    w_bit_nxt   = r_bit_cnt + 1'b1;
                    w_state_nxt = (r_bit_cnt == LAST_BIT) ? UART_STOP : UART_DATA;
                end else begin
                    w_state_nxt = UART_DATA;
                end
            end
            UART_STOP: begin
                if (r_baud == FULL_M1) begin
                    w_baud_nxt  = {BAUD_W{1'b0}};
                    w_state_nxt = UART_IDLE;
                    w_done      = w_rx_s;
                    w_err       = ~w_rx_s;
                end else begin
                    w_state_nxt = UART_STOP;
                end
            end
            default: begin
                w_state_nxt = UART_IDLE;
                w_baud_nxt  = {BAUD_W{1'b0}};
            end
        endcase
    end

    assign o_byte_data = r_shift;
    assign o_byte_done = w_done;
    assign o_byte_err  = w_err;
    assign o_busy      = uart_is_busy(r_state);

endmodule

// File: rtl/uart_rx_word.sv
// Receive-side word register for the MIRCore UART: packs bytes LSB-lane first
// into a word and hands it to the core with a valid/ack handshake.
module uart_rx_word
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 434,
    parameter int BYTES_PER_WORD = 4
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic                                i_rx,
    input  logic                                i_rd_ack,
    output logic [DATA_BITS*BYTES_PER_WORD-1:0] o_rx_word,
    output logic                                o_rx_valid,
    output logic                                o_frame_err,
    output logic                                o_overrun,
    output logic                                o_busy
);

    localparam int WORD_W = DATA_BITS * BYTES_PER_WORD;
    localparam int CNT_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(BYTES_PER_WORD - 1);

    logic [BYTES_PER_WORD-1:0][DATA_BITS-1:0] r_lanes;
    logic [BYTES_PER_WORD-1:0][DATA_BITS-1:0] w_lanes;
    logic [CNT_W-1:0]     r_byte_cnt;
    logic [WORD_W-1:0]    r_rx_word;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic [DATA_BITS-1:0] w_byte_data;
    logic                 w_byte_done;
    logic                 w_byte_err;
    logic                 w_busy;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_rx        (i_rx),
        .o_byte_data (w_byte_data),
        .o_byte_done (w_byte_done),
        .o_byte_err  (w_byte_err),
        .o_busy      (w_busy)
    );

    // Lanes with the incoming byte merged in, so the final byte lands in the word directly
    always_comb begin
        w_lanes             = r_lanes;
        w_lanes[r_byte_cnt] = w_byte_data;
    end

    // Word assembly and handshake flags; a completing word takes priority over rd_ack
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lanes     <= '0;
            r_byte_cnt  <= {CNT_W{1'b0}};
            r_rx_word   <= {WORD_W{1'b0}};
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (i_rd_ack) begin
                r_rx_valid  <= 1'b0;
                r_frame_err <= 1'b0;
                r_overrun   <= 1'b0;
            end
            if (w_byte_done) begin
                r_lanes <= w_lanes;
                if (r_byte_cnt == LAST_LANE) begin
                    r_byte_cnt <= {CNT_W{1'b0}};
                    r_rx_word  <= w_lanes;
                    r_rx_valid <= 1'b1;
                    if (r_rx_valid && !i_rd_ack) begin
                        r_overrun <= 1'b1;
                    end
                end else begin
                    r_byte_cnt <= r_byte_cnt + 1'b1;
                end
            end else if (w_byte_err) begin
                r_frame_err <= 1'b1;
                r_byte_cnt  <= {CNT_W{1'b0}};
            end
        end
    end

    assign o_rx_word   = r_rx_word;
    assign o_rx_valid  = r_rx_valid;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
    assign o_busy      = w_busy;

endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word at 16 clocks per bit; expected words go
// through a scoreboard queue and are popped when rx_word updates.
module tb_uart_rx_word;

    localparam int CPB = 16;
    localparam int BPW = 4;
    localparam int FRAME_CYC = 10 * CPB;
    // Negedge index inside the last frame where the stop bit is sampled:
    // 2 sync cycles + 1 IDLE detect + CPB/2 + 9*CPB.
    localparam int STOP_CYC = 3 + CPB / 2 + 9 * CPB - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic        rd_ack;
    logic [31:0] rx_word;
    logic        rx_valid;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    logic        prev_valid;
    logic        prev_busy;
    logic [31:0] prev_word;

    uart_rx_word #(
        .CLKS_PER_BIT   (CPB),
        .BYTES_PER_WORD (BPW)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_rx        (rx),
        .i_rd_ack    (rd_ack),
        .o_rx_word   (rx_word),
        .o_rx_valid  (rx_valid),
        .o_frame_err (frame_err),
        .o_overrun   (overrun),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int ack_at, input int n_cyc);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int k = 0; k < n_cyc; k++) begin
            @(negedge clk);
            rx     = frame[k / CPB];
            rd_ack = (k == ack_at);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int ack_at);
        exp_q.push_back(w);
        for (int i = 0; i < BPW; i++) begin
            send_frame(w[8*i +: 8], 1'b1, (i == BPW - 1) ? ack_at : -1, FRAME_CYC);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx     = 1'b1;
            rd_ack = 1'b0;
        end
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
    endtask

    // Scoreboard: a new or changed valid word must match the queue head, with busy dropping alongside
    always @(negedge clk) begin
        if (reset !== 1'b1 && rx_valid === 1'b1 &&
            (prev_valid !== 1'b1 || rx_word !== prev_word)) begin
            check("word_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("rx_word", rx_word, exp_q.pop_front());
            end
            check("busy_drop", 32'({prev_busy, busy}), 32'd2);
        end
        prev_valid <= rx_valid;
        prev_busy  <= busy;
        prev_word  <= rx_word;
    end

    initial begin
        reset  = 1'b1;
        rx     = 1'b1;
        rd_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_word", rx_word, 32'h0);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        idle(5);

        // single word, held until acknowledged
        send_word(32'hDEADBEEF, -1);
        idle(10);
        check("single_valid_hold", 32'(rx_valid), 32'd1);
        check("single_word", rx_word, 32'hDEADBEEF);
        pulse_ack();
        check("single_ack_clr", 32'(rx_valid), 32'd0);

        // false start: 5 low cycles
        repeat (5) begin
            @(negedge clk);
            rx = 1'b0;
        end
        @(negedge clk);
        rx = 1'b1;
        check("fs_busy_start", 32'(busy), 32'd1);
        idle(20);
        check("fs_busy_idle", 32'(busy), 32'd0);
        check("fs_valid", 32'(rx_valid), 32'd0);
        check("fs_frame_err", 32'(frame_err), 32'd0);
        send_word(32'h12345678, -1);
        idle(5);
        check("fs_word_valid", 32'(rx_valid), 32'd1);
        pulse_ack();

        // framing error drops the partial word
        send_frame(8'h11, 1'b1, -1, FRAME_CYC);
        send_frame(8'h22, 1'b1, -1, FRAME_CYC);
        send_frame(8'h33, 1'b0, -1, FRAME_CYC);
        check("fe_flag", 32'(frame_err), 32'd1);
        check("fe_valid", 32'(rx_valid), 32'd0);
        idle(20);
        send_word(32'hDDCCBBAA, -1);
        idle(5);
        check("fe_sticky", 32'(frame_err), 32'd1);
        check("fe_word", rx_word, 32'hDDCCBBAA);
        pulse_ack();
        check("fe_ack_flag", 32'(frame_err), 32'd0);
        check("fe_ack_valid", 32'(rx_valid), 32'd0);

        // overrun: two back-to-back words, no ack
        send_word(32'h00000001, -1);
        send_word(32'h00000002, -1);
        idle(5);
        check("ovr_word", rx_word, 32'h00000002);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_valid", 32'(rx_valid), 32'd1);
        pulse_ack();
        check("ovr_ack_valid", 32'(rx_valid), 32'd0);
        check("ovr_ack_flag", 32'(overrun), 32'd0);

        // rd_ack in the completion cycle of a word arriving over an unconsumed one
        send_word(32'h0BADF00D, -1);
        send_word(32'hCAFEF00D, STOP_CYC);
        idle(2);
        check("col_valid", 32'(rx_valid), 32'd1);
        check("col_overrun", 32'(overrun), 32'd0);
        check("col_word", rx_word, 32'hCAFEF00D);

        // reset during data bit 4
        send_frame(8'h5A, 1'b1, -1, 5 * CPB + CPB / 2);
        check("mid_busy", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(rx_valid), 32'd0);
        check("mid_rst_word", rx_word, 32'h0);
        idle(5);
        send_word(32'h89ABCDEF, -1);
        idle(5);
        check("post_rst_valid", 32'(rx_valid), 32'd1);
        check("post_rst_word", rx_word, 32'h89ABCDEF);
        pulse_ack();

        idle(5);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
